mux_arb_reg: RTL

- Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two modes:
  - fixed-select: the channel is chosen by sel.
  - round-robin: fair arbitration among valid channels.
- Used where several vector-unit requesters (operand fetch, writeback, address generation) share one memory-side port.
- Output is held in a one-entry register so downstream stalls never change presented data.

---
 rtl/mux_arb_reg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mux_arb_reg.sv
// N-channel registered multiplexer with valid/ready on every port.
// Channel choice is either a fixed select index or a round-robin arbiter.
module mux_arb_reg #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);
  localparam logic [N-1:0]    ONE   = N'(1);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

  logic            load_en_s;
  logic            grant_any_s;
  logic [SELW-1:0] grant_idx_s;
  logic [N-1:0]    grant_s;
  logic            xfer_s;
  logic [SELW:0]   cand_s;

  // Grant selection: first valid channel from rr_ptr (wrapping at N), or the sel channel.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        cand_s = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (cand_s >= N_EXT) begin
          cand_s = cand_s - N_EXT;
        end else begin
          cand_s = cand_s;
        end
        if (!grant_any_s && in_valid[cand_s[SELW-1:0]]) begin
          grant_any_s = 1'b1;
          grant_idx_s = cand_s[SELW-1:0];
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      // An out-of-range sel simply matches no channel.
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_any_s = 1'b1;
          grant_idx_s = SELW'(i);
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end
  end

  // Handshake qualification against the output register occupancy.
  always_comb begin
    load_en_s = !out_valid_q || out_ready;
    grant_s   = grant_any_s ? (ONE << grant_idx_s) : '0;
    xfer_s    = grant_any_s && load_en_s;
    if (rst_n && load_en_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_s) begin
      out_data_d  = in_data[grant_idx_s*W +: W];
      out_chan_d  = grant_idx_s;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = (grant_idx_s == LAST) ? '0 : grant_idx_s + SELW'(1);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
